// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges primary retirement writes with a queued secondary stream.
// Optional trace printing of issued writes is enabled by defining WB_TRACE_EN.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    input  logic [4:0]  chk_a,
    output logic        chk_hit,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_wpc
);

    localparam int unsigned SLOTS = 1 << PTR_W;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]       a3_q [SLOTS];
    logic [4:0]       a3_d [SLOTS];
    logic [31:0]      wd_q [SLOTS];
    logic [31:0]      wd_d [SLOTS];
    logic [31:0]      pc_q [SLOTS];
    logic [31:0]      pc_d [SLOTS];
    logic [SLOTS-1:0] live_q, live_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        grf_we_q, grf_we_d;
    logic [4:0]  grf_a3_q, grf_a3_d;
    logic [31:0] grf_wd_q, grf_wd_d;
    logic [31:0] grf_wpc_q, grf_wpc_d;

    logic p_eff;
    logic enq;
    logic deq;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign s_ready = (count_q < CNT_W'(DEPTH)) && !reset;
    assign p_eff   = p_we && (p_a3 != 5'd0);
    assign enq     = s_valid && s_ready && (s_a3 != 5'd0);
    assign deq     = !p_eff && (count_q != '0);

    always_comb begin
        a3_d      = a3_q;
        wd_d      = wd_q;
        pc_d      = pc_q;
        live_d    = live_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        grf_we_d  = 1'b0;
        grf_a3_d  = grf_a3_q;
        grf_wd_d  = grf_wd_q;
        grf_wpc_d = grf_wpc_q;

        if (p_eff) begin
            grf_we_d  = 1'b1;
            grf_a3_d  = p_a3;
            grf_wd_d  = p_wd;
            grf_wpc_d = p_pc;
        end else if (deq && live_q[rd_ptr_q]) begin
            grf_we_d  = 1'b1;
            grf_a3_d  = a3_q[rd_ptr_q];
            grf_wd_d  = wd_q[rd_ptr_q];
            grf_wpc_d = pc_q[rd_ptr_q];
        end

        // A younger primary write kills older queued writes to the same register.
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (p_eff && (a3_q[i] == p_a3)) begin
                live_d[i] = 1'b0;
            end
        end

        if (deq) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = next_ptr(rd_ptr_q);
        end

        // Applied after the squash so a same-cycle enqueue to the primary's register survives.
        if (enq) begin
            a3_d[wr_ptr_q]   = s_a3;
            wd_d[wr_ptr_q]   = s_wd;
            pc_d[wr_ptr_q]   = s_pc;
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end

        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!enq && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        chk_hit = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (live_q[i] && (a3_q[i] == chk_a)) begin
                chk_hit = 1'b1;
            end
        end
        if (chk_a == 5'd0) begin
            chk_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            grf_we_q  <= 1'b0;
            grf_a3_q  <= '0;
            grf_wd_q  <= '0;
            grf_wpc_q <= '0;
        end else begin
            live_q    <= live_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            grf_we_q  <= grf_we_d;
            grf_a3_q  <= grf_a3_d;
            grf_wd_q  <= grf_wd_d;
            grf_wpc_q <= grf_wpc_d;
        end
    end

    always_ff @(posedge clk) begin
        a3_q <= a3_d;
        wd_q <= wd_d;
        pc_q <= pc_d;
    end

    assign grf_we  = grf_we_q;
    assign grf_a3  = grf_a3_q;
    assign grf_wd  = grf_wd_q;
    assign grf_wpc = grf_wpc_q;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (grf_we_q && (grf_a3_q != 5'd0)) begin
            $display("%d@%h: $%d <= %h", $time, grf_wpc_q, grf_a3_q, grf_wd_q);
        end
    end
`else
`endif

endmodule
